// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: WIDTH-bit add/sub sequenced one nibble per clock through a shared 4-bit RCA.
module rca4 (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
        assign c[i + 1] = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
    end
    assign cout = c[4];
endmodule

module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_lat, b_eff, work;
    logic             carry, ncout, last;
    logic [3:0]       nsum;

    rca4 u_rca (
        .in1 (a_lat[4*idx +: 4]),
        .in2 (b_eff[4*idx +: 4]),
        .cin (carry),
        .sum (nsum),
        .cout(ncout)
    );

    assign last = idx == IW'(NIBBLES - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            a_lat    <= '0;
            b_eff    <= '0;
            work     <= '0;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                a_lat <= a;
                b_eff <= op_sub ? ~b : b;
                carry <= op_sub;
                idx   <= '0;
                state <= RUN;
            end
        end else if (state == RUN) begin
            work[4*idx +: 4] <= nsum;
            carry            <= ncout;
            idx              <= idx + IW'(1);
            // Final nibble comes straight from the RCA, so the full word is assembled here.
            if (last) begin
                result   <= {nsum, work[WIDTH-5:0]};
                cout     <= ncout;
                overflow <= (a_lat[WIDTH-1] == b_eff[WIDTH-1]) && (nsum[3] != a_lat[WIDTH-1]);
                state    <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: directed stimulus with an arithmetic reference model compared every cycle.
module tb_rca_seq_ctrl;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clock = 1'b0, reset = 1'b1, start = 1'b0, op_sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout, overflow;
    logic [W-1:0] result;
    int           checks = 0, errors = 0;

    rca_seq_ctrl #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer arithmetic, flags from range tests rather than bit tricks.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int ux = int'(x), uy = int'(y);
        int sx = int'($signed(x)), sy = int'($signed(y));
        int ur = s ? ux - uy : ux + uy;
        int sr = s ? sx - sy : sx + sy;
        logic c = s ? (ux >= uy) : (ur >= 2 ** W);
        logic o = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
        logic [W-1:0] r = W'(ur);
        return {o, c, r};
    endfunction

    logic [W-1:0] m_a, m_b, e_res;
    logic         m_sub, e_c, e_o;
    int           rem;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rem   <= 0;
            e_res <= '0;
            e_c   <= 1'b0;
            e_o   <= 1'b0;
        end else if (rem == 0) begin
            if (start) begin
                rem   <= N + 1;
                m_a   <= a;
                m_b   <= b;
                m_sub <= op_sub;
            end
        end else begin
            rem <= rem - 1;
            if (rem == 2) {e_o, e_c, e_res} <= ref_op(m_a, m_b, m_sub);
        end
    end

    always @(negedge clock) begin
        chk("busy", 32'(busy), 32'(rem != 0));
        chk("done", 32'(done), 32'(rem == 1));
        chk("result", 32'(result), 32'(e_res));
        chk("cout", 32'(cout), 32'(e_c));
        chk("overflow", 32'(overflow), 32'(e_o));
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        int cnt = 0;
        @(negedge clock);
        a = x; b = y; op_sub = s; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        while (!done && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        chk("latency", 32'(cnt), N);
        chk("lit_result", 32'(result), 32'(er));
        chk("lit_cout", 32'(cout), 32'(ec));
        chk("lit_overflow", 32'(overflow), 32'(eo));
        @(negedge clock);
    endtask

    initial begin
        int first_done = -1, second_done = -1;
        logic [W-1:0] first_res = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", 32'(result), 32'd0);

        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

        // start held high while operands churn every cycle
        @(negedge clock);
        a = 16'h1111; b = 16'h2222; op_sub = 1'b0; start = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clock);
            if (done && first_done < 0) begin
                first_done = j;
                first_res = result;
            end else if (done && second_done < 0) begin
                second_done = j;
            end
            a = W'($urandom);
            b = W'($urandom);
            op_sub = 1'($urandom);
        end
        start = 1'b0;
        chk("hs_first_done", 32'(first_done), N + 1);
        chk("hs_spacing", 32'(second_done - first_done), N + 2);
        chk("hs_first_result", 32'(first_res), 32'h3333);
        repeat (8) @(negedge clock);

        // asynchronous abort after two RUN cycles
        a = 16'h1234; b = 16'h0FFF; op_sub = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-multiplexing one instance of the team's 4-bit RCA, one nibble per clock, LSB nibble first. It latches operands on a start/busy/done handshake, carries the ripple carry between nibbles in a register, and presents a stable result with carry-out and signed-overflow flags. It is the wide-arithmetic front end for the lab datapath, sitting between operand sources and the shared adder slice.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
NIBBLES, WIDTH/4, derived; number of RCA passes per operation (not overridden)

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op_sub  input  1  0 = a+b, 1 = a-b; latched with operands
a  input  WIDTH  operand A; latched at start acceptance
b  input  WIDTH  operand B; latched at start acceptance
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result/flags valid from this cycle
result  output  WIDTH  sum/difference; held until the next completion
cout  output  1  final carry; for subtract, 1 = no borrow
overflow  output  1  two's-complement signed overflow of the operation

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, result=0, cout=0, overflow=0; nibble index=0, carry register=0, operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE: on a rising edge with start=1, latch a, op_sub, and b_eff = op_sub ? ~b : b; carry register <= op_sub; index <= 0; go to RUN. start=0 stays in IDLE.
- RUN: the RCA is driven combinationally with in1=a_lat[4i+3:4i], in2=b_eff[4i+3:4i], cin=carry register. Each edge writes the RCA sum into working nibble i, loads the carry register with the RCA cout, and increments i.
- RUN on i=NIBBLES-1: transfer the complete working value to result, set cout = RCA cout, set overflow = (a_lat[MSB]==b_eff[MSB]) && (sum[MSB]!=a_lat[MSB]), and go to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally return to IDLE on the next edge.
- Latency: start accepted at edge k; done high in the cycle after edge k+NIBBLES. For WIDTH=16 that is 4 RUN cycles, so the next start is accepted no earlier than edge k+NIBBLES+2.
- start while busy (RUN or DONE) is ignored and is not queued. Changes to a, b, or op_sub after acceptance have no effect.
- result, cout, and overflow change only at the RUN→DONE edge. Between operations they hold their previous values and never show partial nibbles.
- Width: all arithmetic is modulo 2^WIDTH. Any carry beyond the MSB goes only to cout.
- Reset asserted mid-RUN aborts the operation. Outputs return to their reset values, and no done pulse is produced for the aborted operation.
- Simultaneous start and reset: reset wins, and the start is lost.

Test Plan:
- Add, WIDTH=16: a=0x1234, b=0x0FFF, op_sub=0, one-cycle start → busy for 5 cycles, done pulse after 4 RUN cycles, result=0x2233, cout=0, overflow=0.
- Carry chain wrap: a=0xFFFF, b=0x0001 add → result=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001 add → result=0x8000, cout=0, overflow=1.
- Subtract with borrow: a=0x0005, b=0x0007, op_sub=1 → result=0xFFFE, cout=0, overflow=0. Then a=0x8000, b=0x0001, op_sub=1 → result=0x7FFF, cout=1, overflow=1.
- Handshake: hold start=1 continuously and change a/b every cycle during RUN → first operands used, ops back-to-back exactly NIBBLES+2 cycles apart, result stable between done pulses.
- Reset mid-op: start 0x1234+0x0FFF, assert reset asynchronously (off clock edge) after 2 RUN cycles → all outputs 0 immediately, no done; after release, a new 0x0001+0x0001 gives result=0x0002.
- Boundary: 0x0000+0x0000 add → result=0x0000, cout=0, overflow=0. 0x0000-0x0000 sub → result=0x0000, cout=1, overflow=0.
